pulse_sequencer: RTL and testbench
==================================

# pulse_sequencer

Frame-level scheduler for a bank of 200 MHz pulse-channel drivers. It steps through a programmable table of up to STEP_NUM firing steps at each frame tick. For each step it loads that channel's pulse parameters into per-channel holding registers, then issues the channel's sync edge. Its outputs drive the sync and hit/gnd/count/hush inputs of CH_NUM pulse channels, which hold their parameters stable while firing.

## Interface
- CH_NUM, 4: number of driven channels (2..8); channel field is 3 bits, and values ≥ CH_NUM are ignored.
- STEP_NUM, 8: table depth (fixed 3-bit address).
- rst_n  in  1  asynchronous, active-low reset.
- hi_clk  in  1  200 MHz clock.
- i_enable  in  1  sequencer run enable.
- i_period  in  24  frame period in hi_clk ticks; 0 means 2^24.
- i_step_count  in  4  active steps per frame (0 = no firing, 9..15 clamp to 8).
- i_wr  in  1  table write strobe.
- i_wr_addr  in  3  table row.
- i_wr_data  in  57  {ch[2:0], step_len[15:0], hit_len[7:0], gnd_len[7:0], pulse_count[3:0], hush_len[15:0]}.
- i_clr_ovr  in  1  clears o_overrun.
- o_sync  out  CH_NUM  per-channel sync.
- o_hit_len  out  8*CH_NUM  per-channel hit length.
- o_gnd_len  out  8*CH_NUM  per-channel gnd length.
- o_pulse_count  out  4*CH_NUM  per-channel pulse count.
- o_hush_len  out  16*CH_NUM  per-channel hush length.
- o_frame_start  out  1  one-cycle frame tick.
- o_step_idx  out  3  current step.
- o_busy  out  1  sequence in progress.
- o_overrun  out  1  sticky frame-overrun flag.

## Operation
- Frame counter:
  - Held at 0 while i_enable = 0.
  - While enabled, counts 0..i_period-1 and wraps.
  - o_frame_start = enabled && counter == 0.
- FSM states IDLE, LOAD, SYNC, SLOT.
- IDLE: on o_frame_start with i_step_count ≠ 0 → LOAD, step = 0.
- LOAD (1 cycle):
  - Reads table[step].
  - Writes its hit/gnd/count/hush fields into the holding registers of channel ch; other channels are unchanged.
  - → SYNC.
- SYNC (2 cycles): o_sync[ch] = 1 → SLOT.
- SLOT:
  - Waits until the step has lasted max(step_len, 4) cycles, counted from its LOAD cycle.
  - Then, if step+1 < clamped step_count → LOAD with step+1; else → IDLE.
- Invalid channel (ch ≥ CH_NUM): LOAD writes nothing, SYNC drives no bit, and slot timing is still honoured.
- o_busy = 1 in LOAD/SYNC/SLOT.
- o_step_idx = current step.
- Table writes are accepted in any state. A write to the row being read in the same LOAD cycle does not affect that LOAD, which uses the old contents.
- Frame tick while o_busy:
  - The frame is skipped; the sequence continues and does not restart.
  - The next sequence starts at the next tick found in IDLE.
- i_enable low mid-sequence:
  - Next cycle the FSM is in IDLE, o_sync = 0 and the frame counter is 0.
  - Holding registers keep their values.
- Changing i_period mid-frame: takes effect at the next compare, and the counter wraps at the new value. If the counter is already ≥ the new period, it runs on to 2^24 and wraps.

## Timing
- Reset values: all outputs 0, including every holding register, o_sync, o_busy, o_step_idx, o_overrun and o_frame_start. FSM in IDLE, table contents undefined.
- Frame tick at cycle T → LOAD at T+1. Holding registers are valid from T+2, and o_sync is high at T+2 and T+3.
  - Parameters are therefore stable at least one cycle before the sync edge.
- Consecutive steps: next LOAD is exactly max(step_len, 4) cycles after the previous LOAD.
- The minimum slot of 4 guarantees a sync low gap of ≥ 2 cycles for back-to-back steps on the same channel.
- First frame after enabling: the first cycle with i_enable = 1 is a frame tick.

## Configuration
- PULSE_SEQ_OVERRUN_EN defined:
  - A frame tick while o_busy sets o_overrun, which stays sticky until i_clr_ovr.
  - If set and clear occur in the same cycle, set wins.
- PULSE_SEQ_OVERRUN_EN undefined:
  - o_overrun is constant 0 and i_clr_ovr is ignored.
  - Overrun frames are still skipped silently.

## Test plan
- Single step: row 0 = {ch 1, step_len 10, hit 5, gnd 3, count 2, hush 100}, step_count 1, period 50, enable at cycle 0.
  - o_hit_len[15:8] = 5 from cycle 2.
  - o_sync[1] high at cycles 2-3.
  - Repeats at cycles 50, 100.
- Three steps on ch 0, 2, 3 with step_len 20: LOADs at 1, 21, 41, with each channel's sync 1 cycle after its LOAD.
- step_len 1 back-to-back on ch 0, two steps: LOADs 4 cycles apart, and o_sync[0] shows two separate 2-cycle pulses.
- Overrun: step_len 40 × 2 steps, period 50.
  - The tick at 50 is skipped and o_overrun = 1 (0 without the macro).
  - i_clr_ovr clears it.
  - The next sequence starts at cycle 100.
- Deassert i_enable at a cycle in SYNC: o_sync drops next cycle, and holding registers are retained.
  - Re-enable: a frame tick occurs on the first enabled cycle.
- Reset asserted mid-SLOT: all outputs 0 immediately, and the FSM is in IDLE after release.

Source files
------------

// File: rtl/pulse_sequencer.sv
// pulse_sequencer: frame-level scheduler for a bank of pulse-channel drivers.
// Each frame tick walks a table of up to STEP_NUM steps; every step loads one
// channel's hit/gnd/count/hush holding registers, then raises that channel's
// sync for two cycles, then waits out the rest of its slot.
// Optional feature: define PULSE_SEQ_OVERRUN_EN for a sticky frame-overrun flag.
module pulse_sequencer #(
  parameter int CH_NUM   = 4,
  parameter int STEP_NUM = 8
) (
  input  logic                   rst_n,
  input  logic                   hi_clk,
  input  logic                   i_enable,
  input  logic [23:0]            i_period,
  input  logic [3:0]             i_step_count,
  input  logic                   i_wr,
  input  logic [2:0]             i_wr_addr,
  input  logic [56:0]            i_wr_data,
  input  logic                   i_clr_ovr,
  output logic [CH_NUM-1:0]      o_sync,
  output logic [8*CH_NUM-1:0]    o_hit_len,
  output logic [8*CH_NUM-1:0]    o_gnd_len,
  output logic [4*CH_NUM-1:0]    o_pulse_count,
  output logic [16*CH_NUM-1:0]   o_hush_len,
  output logic                   o_frame_start,
  output logic [2:0]             o_step_idx,
  output logic                   o_busy,
  output logic                   o_overrun
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SYNC,
    S_SLOT
  } state_t;

  state_t      state;
  state_t      state_n;

  logic [23:0] frame_cnt;
  logic [23:0] period_m1;
  logic        frame_tick;

  logic [2:0]  step_q;
  logic [15:0] slot_cyc;
  logic [2:0]  cur_ch;
  logic [15:0] cur_len;
  logic [15:0] eff_len_m1;
  logic [3:0]  steps_clamped;
  logic        last_step;

  // Row layout {ch, step_len, hit, gnd, count, hush} is 55 bits; the top two
  // bits of the 57-bit write word carry nothing.
  logic [54:0] table_mem [STEP_NUM];
  logic [54:0] rd_row;
  logic        unused_wr_bits;

  assign unused_wr_bits = ^i_wr_data[56:55];

  // Period 0 wraps to all-ones, i.e. a full 2^24 frame.
  assign period_m1     = i_period - 24'd1;
  assign frame_tick    = rst_n & i_enable & (frame_cnt == '0);
  assign o_frame_start = frame_tick;

  assign steps_clamped = (i_step_count > 4'(STEP_NUM)) ? 4'(STEP_NUM) : i_step_count;
  assign last_step     = (({1'b0, step_q} + 4'd1) >= steps_clamped);
  assign eff_len_m1    = (cur_len < 16'd4) ? 16'd3 : (cur_len - 16'd1);

  assign rd_row        = table_mem[step_q];
  assign o_busy        = (state != S_IDLE);
  assign o_step_idx    = step_q;

  // Frame counter: cleared while disabled, equality wrap so a period shrunk
  // below the current count runs on to the 24-bit rollover.
  always_ff @(posedge hi_clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= '0;
    end else if (!i_enable) begin
      frame_cnt <= '0;
    end else if (frame_cnt == period_m1) begin
      frame_cnt <= '0;
    end else begin
      frame_cnt <= frame_cnt + 24'd1;
    end
  end

  // Step table storage; writes land at the clock edge, so a LOAD reading the
  // same row in the same cycle sees the previous contents.
  always_ff @(posedge hi_clk) begin
    if (i_wr) begin
      table_mem[i_wr_addr] <= i_wr_data[54:0];
    end
  end

  // FSM state register.
  always_ff @(posedge hi_clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state and sync decode; slot_cyc counts cycles since the step's LOAD.
  always_comb begin
    state_n = state;
    o_sync  = '0;
    unique case (state)
      S_IDLE: begin
        if (frame_tick && (steps_clamped != '0)) begin
          state_n = S_LOAD;
        end
      end
      S_LOAD: begin
        state_n = S_SYNC;
      end
      S_SYNC: begin
        for (int unsigned c = 0; c < CH_NUM; c++) begin
          if (cur_ch == 3'(c)) begin
            o_sync[c] = 1'b1;
          end
        end
        if (slot_cyc >= 16'd2) begin
          state_n = S_SLOT;
        end
      end
      S_SLOT: begin
        if (slot_cyc >= eff_len_m1) begin
          state_n = last_step ? S_IDLE : S_LOAD;
        end
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
    if (!i_enable) begin
      state_n = S_IDLE;
    end
  end

  // Step index, slot timer and the latched channel/length of the current step.
  always_ff @(posedge hi_clk or negedge rst_n) begin
    if (!rst_n) begin
      step_q   <= '0;
      slot_cyc <= '0;
      cur_ch   <= '0;
      cur_len  <= '0;
    end else begin
      if (state_n == S_LOAD) begin
        slot_cyc <= '0;
      end else if (state != S_IDLE) begin
        slot_cyc <= slot_cyc + 16'd1;
      end
      if ((state == S_IDLE) && (state_n == S_LOAD)) begin
        step_q <= '0;
      end else if ((state == S_SLOT) && (state_n == S_LOAD)) begin
        step_q <= step_q + 3'd1;
      end
      if (state == S_LOAD) begin
        cur_ch  <= rd_row[54:52];
        cur_len <= rd_row[51:36];
      end
    end
  end

  // Per-channel holding registers, written only for the addressed channel.
  always_ff @(posedge hi_clk or negedge rst_n) begin
    if (!rst_n) begin
      o_hit_len     <= '0;
      o_gnd_len     <= '0;
      o_pulse_count <= '0;
      o_hush_len    <= '0;
    end else if (state == S_LOAD) begin
      for (int unsigned c = 0; c < CH_NUM; c++) begin
        if (rd_row[54:52] == 3'(c)) begin
          o_hit_len[8*c +: 8]      <= rd_row[35:28];
          o_gnd_len[8*c +: 8]      <= rd_row[27:20];
          o_pulse_count[4*c +: 4]  <= rd_row[19:16];
          o_hush_len[16*c +: 16]   <= rd_row[15:0];
        end
      end
    end
  end

`ifdef PULSE_SEQ_OVERRUN_EN
  // Sticky overrun: a tick arriving mid-sequence sets it, set beats clear.
  always_ff @(posedge hi_clk or negedge rst_n) begin
    if (!rst_n) begin
      o_overrun <= 1'b0;
    end else if (frame_tick && o_busy) begin
      o_overrun <= 1'b1;
    end else if (i_clr_ovr) begin
      o_overrun <= 1'b0;
    end
  end
`else
  logic unused_clr_ovr;
  assign unused_clr_ovr = i_clr_ovr;
  assign o_overrun      = 1'b0;
`endif

endmodule

// File: tb/tb_pulse_sequencer.sv
// Bench for pulse_sequencer: a time-based model (steps occupy
// [load, load+max(len,4)) windows) checked every cycle, plus literal pins.
`timescale 1ns/1ps
module tb_pulse_sequencer;
  localparam int CH = 4;
`ifdef PULSE_SEQ_OVERRUN_EN
  localparam bit OVR_EN = 1'b1;
`else
  localparam bit OVR_EN = 1'b0;
`endif

  logic            rst_n, hi_clk, i_enable, i_wr, i_clr_ovr;
  logic [23:0]     i_period;
  logic [3:0]      i_step_count;
  logic [2:0]      i_wr_addr;
  logic [56:0]     i_wr_data;
  logic [CH-1:0]   o_sync;
  logic [8*CH-1:0] o_hit_len, o_gnd_len;
  logic [4*CH-1:0] o_pulse_count;
  logic [16*CH-1:0] o_hush_len;
  logic            o_frame_start, o_busy, o_overrun;
  logic [2:0]      o_step_idx;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int c0 = 0;

  pulse_sequencer #(.CH_NUM(CH), .STEP_NUM(8)) dut (
    .rst_n(rst_n), .hi_clk(hi_clk), .i_enable(i_enable), .i_period(i_period),
    .i_step_count(i_step_count), .i_wr(i_wr), .i_wr_addr(i_wr_addr),
    .i_wr_data(i_wr_data), .i_clr_ovr(i_clr_ovr), .o_sync(o_sync),
    .o_hit_len(o_hit_len), .o_gnd_len(o_gnd_len), .o_pulse_count(o_pulse_count),
    .o_hush_len(o_hush_len), .o_frame_start(o_frame_start),
    .o_step_idx(o_step_idx), .o_busy(o_busy), .o_overrun(o_overrun)
  );

  initial hi_clk = 1'b0;
  always #5 hi_clk = ~hi_clk;
  always @(posedge hi_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, cyc - c0, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [56:0] mtab [8];
  logic [7:0]  mh_hit [CH];
  logic [7:0]  mh_gnd [CH];
  logic [3:0]  mh_cnt [CH];
  logic [15:0] mh_hush [CH];
  bit          m_act, m_ovr;
  int          m_k, m_ld, m_len, m_ch, m_age;
  logic [56:0] m_row;

  initial begin
    for (int i = 0; i < 8; i++) mtab[i] = '0;
    m_act = 0; m_ovr = 0; m_k = 0; m_ld = 0; m_len = 4; m_ch = 0; m_age = 0;
    m_row = '0;
  end

  always @(negedge hi_clk) begin : model
    int t, per, ncl;
    bit tick;
    logic [CH-1:0]    e_sync;
    logic [8*CH-1:0]  e_hit, e_gnd;
    logic [4*CH-1:0]  e_cnt;
    logic [16*CH-1:0] e_hush;
    t = cyc;
    if (!rst_n) begin
      m_act = 0; m_ovr = 0; m_age = 0;
      for (int c = 0; c < CH; c++) begin
        mh_hit[c] = '0; mh_gnd[c] = '0; mh_cnt[c] = '0; mh_hush[c] = '0;
      end
      chk("rst_sync", o_sync, 0);
      chk("rst_busy", o_busy, 0);
      chk("rst_fs", o_frame_start, 0);
      chk("rst_ovr", o_overrun, 0);
      chk("rst_step", o_step_idx, 0);
      chk("rst_hold", {o_hit_len, o_gnd_len} | 64'(o_pulse_count) | o_hush_len, 0);
    end else begin
      per  = (i_period == 0) ? (1 << 24) : int'(i_period);
      ncl  = (i_step_count > 8) ? 8 : int'(i_step_count);
      tick = i_enable && ((m_age % per) == 0);
      if (m_act && t == m_ld + m_len) begin
        if (m_k + 1 < ncl) begin
          m_k  = m_k + 1;
          m_ld = t;
        end else begin
          m_act = 0;
        end
      end
      if (m_act && t == m_ld) begin
        m_row = mtab[m_k];
        m_ch  = int'(m_row[54:52]);
        m_len = (m_row[51:36] < 16'd4) ? 4 : int'(m_row[51:36]);
      end
      e_sync = '0;
      if (m_act && (t == m_ld + 1 || t == m_ld + 2) && m_ch < CH) e_sync[m_ch] = 1'b1;
      for (int c = 0; c < CH; c++) begin
        e_hit[8*c +: 8]    = mh_hit[c];
        e_gnd[8*c +: 8]    = mh_gnd[c];
        e_cnt[4*c +: 4]    = mh_cnt[c];
        e_hush[16*c +: 16] = mh_hush[c];
      end
      chk("m_sync", o_sync, e_sync);
      chk("m_busy", o_busy, m_act);
      chk("m_fs", o_frame_start, tick);
      chk("m_ovr", o_overrun, m_ovr);
      chk("m_hit", o_hit_len, e_hit);
      chk("m_gnd", o_gnd_len, e_gnd);
      chk("m_cnt", o_pulse_count, e_cnt);
      chk("m_hush", o_hush_len, e_hush);
      if (m_act) chk("m_step", o_step_idx, m_k);
      if (m_act && t == m_ld && m_ch < CH) begin
        mh_hit[m_ch]  = m_row[35:28];
        mh_gnd[m_ch]  = m_row[27:20];
        mh_cnt[m_ch]  = m_row[19:16];
        mh_hush[m_ch] = m_row[15:0];
      end
      if (OVR_EN && tick && m_act) m_ovr = 1;
      else if (i_clr_ovr) m_ovr = 0;
      if (tick && !m_act && ncl > 0) begin
        m_act = 1; m_k = 0; m_ld = t + 1; m_len = 4;
      end
      if (!i_enable) m_act = 0;
      m_age = i_enable ? m_age + 1 : 0;
    end
    if (i_wr) mtab[i_wr_addr] = i_wr_data;
  end

  // ---------------- stimulus ----------------
  task automatic next_cycle();
    @(posedge hi_clk);
    #1;
  endtask

  task automatic go(input int rel);
    while (cyc < c0 + rel) next_cycle();
  endtask

  task automatic wr(input int a, input int ch, input int len, input int hit,
                    input int gnd, input int cnt, input int hush);
    next_cycle();
    i_wr      = 1'b1;
    i_wr_addr = 3'(a);
    i_wr_data = {2'b00, 3'(ch), 16'(len), 8'(hit), 8'(gnd), 4'(cnt), 16'(hush)};
    next_cycle();
    i_wr = 1'b0;
  endtask

  task automatic start();
    next_cycle();
    i_enable = 1'b1;
    c0 = cyc;
  endtask

  task automatic stop();
    next_cycle();
    i_enable = 1'b0;
    next_cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cycle=%0d actual=running required=finished", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 0; i_enable = 0; i_period = 24'd50; i_step_count = 0;
    i_wr = 0; i_wr_addr = 0; i_wr_data = '0; i_clr_ovr = 0;
    repeat (3) @(posedge hi_clk);
    #1 rst_n = 1;
    @(negedge hi_clk);
    chk("reset_busy", o_busy, 0);
    chk("reset_sync", o_sync, 0);
    chk("reset_hit", o_hit_len, 0);
    chk("reset_ovr", o_overrun, 0);

    // single step
    wr(0, 1, 10, 5, 3, 2, 100);
    i_period = 24'd50; i_step_count = 4'd1;
    start();
    @(negedge hi_clk); chk("t1_fs0", o_frame_start, 1);
    go(1); @(negedge hi_clk); chk("t1_busy1", o_busy, 1); chk("t1_hit_pre", o_hit_len, 0);
    go(2); @(negedge hi_clk);
    chk("t1_hit", o_hit_len[15:8], 5); chk("t1_gnd", o_gnd_len[15:8], 3);
    chk("t1_cnt", o_pulse_count[7:4], 2); chk("t1_hush", o_hush_len[31:16], 100);
    chk("t1_sync2", o_sync, 4'b0010);
    go(3); @(negedge hi_clk); chk("t1_sync3", o_sync, 4'b0010);
    go(4); @(negedge hi_clk); chk("t1_sync4", o_sync, 4'b0000);
    go(10); @(negedge hi_clk); chk("t1_busy10", o_busy, 1);
    go(11); @(negedge hi_clk); chk("t1_busy11", o_busy, 0);
    go(50); @(negedge hi_clk); chk("t1_fs50", o_frame_start, 1);
    go(52); @(negedge hi_clk); chk("t1_sync52", o_sync, 4'b0010);
    go(100); @(negedge hi_clk); chk("t1_fs100", o_frame_start, 1);
    go(102); @(negedge hi_clk); chk("t1_sync102", o_sync, 4'b0010);
    go(112); stop();

    // three steps, plus a write to row 1 during its own LOAD
    wr(0, 0, 20, 8'h11, 1, 1, 1);
    wr(1, 2, 20, 8'h22, 2, 2, 2);
    wr(2, 3, 20, 8'h33, 3, 3, 3);
    i_period = 24'd100; i_step_count = 4'd3;
    start();
    go(1); @(negedge hi_clk); chk("t2_step0", o_step_idx, 0);
    go(2); @(negedge hi_clk); chk("t2_sync0", o_sync, 4'b0001);
    chk("t2_hit0", o_hit_len[7:0], 8'h11); chk("t2_keep1", o_hit_len[15:8], 5);
    go(21);
    i_wr = 1'b1; i_wr_addr = 3'd1;
    i_wr_data = {2'b00, 3'd2, 16'd20, 8'h2A, 8'd2, 4'd2, 16'd2};
    @(negedge hi_clk); chk("t2_step1", o_step_idx, 1); chk("t2_sync21", o_sync, 0);
    go(22); i_wr = 1'b0;
    @(negedge hi_clk); chk("t2_sync1", o_sync, 4'b0100); chk("t2_old_row", o_hit_len[23:16], 8'h22);
    go(41); @(negedge hi_clk); chk("t2_step2", o_step_idx, 2);
    go(42); @(negedge hi_clk); chk("t2_sync2", o_sync, 4'b1000); chk("t2_hit2", o_hit_len[31:24], 8'h33);
    go(61); @(negedge hi_clk); chk("t2_done", o_busy, 0);
    go(122); @(negedge hi_clk); chk("t2_new_row", o_hit_len[23:16], 8'h2A);
    go(162); stop();

    // step_len 1 back-to-back on channel 0
    wr(0, 0, 1, 7, 0, 0, 0);
    wr(1, 0, 1, 8, 0, 0, 0);
    i_period = 24'd50; i_step_count = 4'd2;
    start();
    go(2); @(negedge hi_clk); chk("t3_s2", o_sync, 4'b0001);
    go(3); @(negedge hi_clk); chk("t3_s3", o_sync, 4'b0001);
    go(4); @(negedge hi_clk); chk("t3_s4", o_sync, 0);
    go(5); @(negedge hi_clk); chk("t3_s5", o_sync, 0); chk("t3_step5", o_step_idx, 1);
    go(6); @(negedge hi_clk); chk("t3_s6", o_sync, 4'b0001); chk("t3_hit6", o_hit_len[7:0], 8);
    go(7); @(negedge hi_clk); chk("t3_s7", o_sync, 4'b0001);
    go(8); @(negedge hi_clk); chk("t3_busy8", o_busy, 1);
    go(9); @(negedge hi_clk); chk("t3_busy9", o_busy, 0);
    go(12); stop();

    // step count clamp to 8, invalid channel rows, min-slot of 4
    for (int a = 0; a < 8; a++) wr(a, (a % 2 == 0) ? 0 : 5, a % 2, 8'h40 + a, a, a, a);
    i_period = 24'd100; i_step_count = 4'd15;
    start();
    go(26); @(negedge hi_clk); chk("t4_sync26", o_sync, 4'b0001); chk("t4_hit26", o_hit_len[7:0], 8'h46);
    go(29); @(negedge hi_clk); chk("t4_step7", o_step_idx, 7);
    go(30); @(negedge hi_clk); chk("t4_inval_sync", o_sync, 0); chk("t4_inval_hit", o_hit_len[7:0], 8'h46);
    go(32); @(negedge hi_clk); chk("t4_busy32", o_busy, 1);
    go(33); @(negedge hi_clk); chk("t4_busy33", o_busy, 0);
    go(36); stop();
    i_step_count = 4'd0;
    start();
    go(1); @(negedge hi_clk); chk("t4_zero_busy", o_busy, 0);
    go(2); stop();

    // overrun
    wr(0, 0, 40, 1, 1, 1, 1);
    wr(1, 1, 40, 2, 2, 2, 2);
    i_period = 24'd50; i_step_count = 4'd2;
    start();
    go(50); @(negedge hi_clk); chk("t5_fs50", o_frame_start, 1); chk("t5_busy50", o_busy, 1);
    go(51); @(negedge hi_clk); chk("t5_ovr", o_overrun, OVR_EN); chk("t5_norestart", o_step_idx, 1);
    go(60); i_clr_ovr = 1'b1;
    go(61); i_clr_ovr = 1'b0;
    @(negedge hi_clk); chk("t5_clr", o_overrun, 0);
    go(81); @(negedge hi_clk); chk("t5_idle81", o_busy, 0);
    go(100); @(negedge hi_clk); chk("t5_fs100", o_frame_start, 1); chk("t5_idle100", o_busy, 0);
    go(101); @(negedge hi_clk); chk("t5_busy101", o_busy, 1); chk("t5_step101", o_step_idx, 0);
    go(150); i_clr_ovr = 1'b1;
    go(151); i_clr_ovr = 1'b0;
    @(negedge hi_clk); chk("t5_setwins", o_overrun, OVR_EN);
    go(185); stop();
    i_clr_ovr = 1'b1; next_cycle(); i_clr_ovr = 1'b0;

    // enable dropped during SYNC
    wr(0, 2, 20, 8'h99, 9, 9, 9);
    i_step_count = 4'd1;
    start();
    go(2); i_enable = 1'b0;
    @(negedge hi_clk); chk("t6_sync2", o_sync, 4'b0100);
    go(3); @(negedge hi_clk);
    chk("t6_sync3", o_sync, 0); chk("t6_busy3", o_busy, 0);
    chk("t6_hold", o_hit_len[23:16], 8'h99); chk("t6_fs3", o_frame_start, 0);
    go(6); i_enable = 1'b1;
    @(negedge hi_clk); chk("t6_refs", o_frame_start, 1);
    go(7); @(negedge hi_clk); chk("t6_rebusy", o_busy, 1);
    go(30); stop();

    // reset mid-SLOT
    wr(0, 3, 30, 8'h77, 7, 7, 7);
    start();
    go(10); rst_n = 1'b0; i_enable = 1'b0;
    @(negedge hi_clk);
    chk("t7_busy", o_busy, 0); chk("t7_hit", o_hit_len, 0); chk("t7_hush", o_hush_len, 0);
    chk("t7_step", o_step_idx, 0);
    go(12); rst_n = 1'b1;
    go(13); @(negedge hi_clk); chk("t7_idle", o_busy, 0);
    wr(0, 3, 30, 8'h77, 7, 7, 7);
    start();
    go(1); @(negedge hi_clk); chk("t7_busy1", o_busy, 1);
    go(2); @(negedge hi_clk); chk("t7_sync2", o_sync, 4'b1000); chk("t7_hit2", o_hit_len[31:24], 8'h77);
    go(35); stop();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
